// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift partition sequencer.
//   state_e     : sequencer FSM states
//   *_DEF       : default partition geometry
//   RD_LAT_MAX  : deepest supported read latency
//   step_wraps  : tells whether the next address step crosses the wrap point
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_DECOUPLED = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 4;
  localparam int unsigned PRESC_W_DEF = 23;
  localparam int unsigned RD_LAT_MAX  = 4;

  // A down-step wraps from the all-zero address, an up-step from all-ones.
  function automatic logic step_wraps(input logic dir, input logic at_min, input logic at_max);
    if (dir) begin
      return at_min;
    end else begin
      return at_max;
    end
  endfunction

endpackage

// File: rtl/shift_seq_capture.sv
// Read-latency token pipe and LED holding register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : a new address was issued this cycle
//   advance_i    : pipe moves and may capture (low while decoupled)
//   data_i       : partition read data
//   led_o        : last captured data, held between captures
//   led_valid_o  : one-cycle pulse when led_o updates
//   pipe_empty_o : no read is outstanding
module shift_seq_capture #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              advance_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] led_o,
  output logic              led_valid_o,
  output logic              pipe_empty_o
);

  logic [RD_LAT-1:0] tok_q, tok_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              valid_q, valid_d;

  // Shift tokens toward the capture end; the oldest token samples data_i.
  always_comb begin
    tok_d   = tok_q;
    led_d   = led_q;
    valid_d = 1'b0;
    if (advance_i) begin
      tok_d    = tok_q << 1'b1;
      tok_d[0] = push_i;
      if (tok_q[RD_LAT-1]) begin
        led_d   = data_i;
        valid_d = 1'b1;
      end else begin
        led_d   = led_q;
        valid_d = 1'b0;
      end
    end else begin
      tok_d   = tok_q;
      led_d   = led_q;
      valid_d = 1'b0;
    end
  end

  // Pipe and LED state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q   <= {RD_LAT{1'b0}};
      led_q   <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      tok_q   <= tok_d;
      led_q   <= led_d;
      valid_q <= valid_d;
    end
  end

  assign led_o        = led_q;
  assign led_valid_o  = valid_q;
  assign pipe_empty_o = (tok_q == {RD_LAT{1'b0}});

endmodule

// File: rtl/shift_sequencer.sv
// Address/enable initiator for one reconfigurable shift partition.
//   clk, rst_n      : clock, asynchronous active-low reset
//   run_i, dir_i    : advance enable, 0 = up / 1 = down
//   presc_max_i     : prescaler terminal count (step every presc_max_i+1 clocks)
//   decouple_req_i  : request partition isolation; decouple_ack_o grants it
//   shift_en_o      : partition enable, low only while decoupled
//   shift_addr_o    : partition address
//   shift_data_i    : partition data, valid RD_LAT clocks after an address step
//   led_out_o       : held captured data; led_valid_o pulses on update
//   wrap_pulse_o    : pulses the cycle after a wrapping step
module shift_sequencer import shift_seq_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  input  logic               dir_i,
  input  logic [PRESC_W-1:0] presc_max_i,
  input  logic               decouple_req_i,
  output logic               decouple_ack_o,
  output logic               shift_en_o,
  output logic [ADDR_W-1:0]  shift_addr_o,
  input  logic [DATA_W-1:0]  shift_data_i,
  output logic [DATA_W-1:0]  led_out_o,
  output logic               led_valid_o,
  output logic               wrap_pulse_o
);

  localparam int unsigned PIPE_D = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                   ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 wrap_pend_q, wrap_pend_d;
  logic                 wrap_q, en_q, ack_q;
  logic                 tick_s, step_s, pipe_empty_s, advance_s;

  // Next-state logic: decouple beats run=0, which beats a prescaler tick.
  always_comb begin
    tick_s      = (presc_q >= presc_max_i);
    step_s      = 1'b0;
    state_d     = state_q;
    presc_d     = presc_q;
    addr_d      = addr_q;
    wrap_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (decouple_req_i) begin
          state_d = ST_DRAIN;
        end else if (run_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (decouple_req_i) begin
          state_d = ST_DRAIN;
          presc_d = {PRESC_W{1'b0}};
        end else if (!run_i) begin
          state_d = ST_IDLE;
          presc_d = {PRESC_W{1'b0}};
        end else if (tick_s) begin
          step_s      = 1'b1;
          presc_d     = {PRESC_W{1'b0}};
          addr_d      = dir_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          wrap_pend_d = step_wraps(dir_i, addr_q == {ADDR_W{1'b0}}, addr_q == {ADDR_W{1'b1}});
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      ST_DRAIN: begin
        if (!decouple_req_i) begin
          state_d = run_i ? ST_RUN : ST_IDLE;
        end else if (pipe_empty_s) begin
          state_d = ST_DECOUPLED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DECOUPLED: begin
        presc_d = {PRESC_W{1'b0}};
        if (!decouple_req_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DECOUPLED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = {PRESC_W{1'b0}};
      end
    endcase
  end

  // FSM, counters and registered outputs; en/ack follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= {PRESC_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
      en_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      addr_q      <= addr_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_pend_q;
      en_q        <= (state_d != ST_DECOUPLED);
      ack_q       <= (state_d == ST_DECOUPLED);
    end
  end

  // Reads in flight keep completing until the partition is isolated.
  assign advance_s = (state_q != ST_DECOUPLED);

  shift_seq_capture #(
    .DATA_W (DATA_W),
    .RD_LAT (PIPE_D)
  ) u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (step_s),
    .advance_i    (advance_s),
    .data_i       (shift_data_i),
    .led_o        (led_out_o),
    .led_valid_o  (led_valid_o),
    .pipe_empty_o (pipe_empty_s)
  );

  assign shift_addr_o   = addr_q;
  assign wrap_pulse_o   = wrap_q;
  assign shift_en_o     = en_q;
  assign decouple_ack_o = ack_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Two sequencers (read latency 1 and 3) share one stimulus stream; each has
// a partition model and an expected-LED queue checked by a monitor.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        dreq = 1'b0;
  logic [22:0] pmax = 23'd0;

  logic        ack_a, en_a, valid_a, wrap_a;
  logic        ack_b, en_b, valid_b, wrap_b;
  logic [11:0] addr_a, addr_b;
  logic [3:0]  data_a, data_b, led_a, led_b;
  logic [3:0]  pb_d0, pb_d1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  int          base_a, base_b;
  logic [3:0]  q_a[$];
  logic [3:0]  q_b[$];

  always #5 clk = ~clk;

  shift_sequencer #(.ADDR_W(12), .DATA_W(4), .PRESC_W(23), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .run_i(run), .dir_i(dir), .presc_max_i(pmax),
    .decouple_req_i(dreq), .decouple_ack_o(ack_a), .shift_en_o(en_a),
    .shift_addr_o(addr_a), .shift_data_i(data_a), .led_out_o(led_a),
    .led_valid_o(valid_a), .wrap_pulse_o(wrap_a));

  shift_sequencer #(.ADDR_W(12), .DATA_W(4), .PRESC_W(23), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run_i(run), .dir_i(dir), .presc_max_i(pmax),
    .decouple_req_i(dreq), .decouple_ack_o(ack_b), .shift_en_o(en_b),
    .shift_addr_o(addr_b), .shift_data_i(data_b), .led_out_o(led_b),
    .led_valid_o(valid_b), .wrap_pulse_o(wrap_b));

  // Partition models: data = addr[3:0], valid RD_LAT clocks after the address.
  assign data_a = addr_a[3:0];
  always @(posedge clk) begin
    pb_d0 <= addr_b[3:0];
    pb_d1 <= pb_d0;
  end
  assign data_b = pb_d1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr_a"}, addr_a, 0);  chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_led_a"}, led_a, 0);    chk({tag, "_led_b"}, led_b, 0);
    chk({tag, "_valid_a"}, valid_a, 0); chk({tag, "_valid_b"}, valid_b, 0);
    chk({tag, "_wrap_a"}, wrap_a, 0);  chk({tag, "_wrap_b"}, wrap_b, 0);
    chk({tag, "_en_a"}, en_a, 0);      chk({tag, "_en_b"}, en_b, 0);
    chk({tag, "_ack_a"}, ack_a, 0);    chk({tag, "_ack_b"}, ack_b, 0);
  endtask

  task automatic chk_addr_wrap(input string tag, input int addr, input int wrap);
    chk({tag, "_addr_a"}, addr_a, addr); chk({tag, "_addr_b"}, addr_b, addr);
    chk({tag, "_wrap_a"}, wrap_a, wrap); chk({tag, "_wrap_b"}, wrap_b, wrap);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_qa_left"}, q_a.size(), 0);
    chk({tag, "_qb_left"}, q_b.size(), 0);
  endtask

  task automatic wait_acks(input string tag);
    for (int i = 0; i < 20 && !(ack_a && ack_b); i++) cyc(1);
    chk({tag, "_ack_a"}, ack_a, 1); chk({tag, "_ack_b"}, ack_b, 1);
    chk({tag, "_en_a"}, en_a, 0);   chk({tag, "_en_b"}, en_b, 0);
  endtask

  // Monitor: every LED update must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a) begin
        cnt_a++;
        if (q_a.size() == 0) chk("led_a_extra", q_a.size(), 1);
        else chk("led_a", led_a, q_a.pop_front());
      end
      if (valid_b) begin
        cnt_b++;
        if (q_b.size() == 0) chk("led_b_extra", q_b.size(), 1);
        else chk("led_b", led_b, q_b.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t1[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    int t2a[5] = '{0, 4095, 4094, 4093, 4092};
    int t2w[5] = '{0, 0, 1, 0, 0};
    int t5[11] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    // Reset values, then enable rises on the first edge after release.
    pmax = 23'd3;
    cyc(2);
    chk_reset("reset");
    rst_n = 1'b1;
    cyc(1);
    chk("en_after_rst_a", en_a, 1); chk("en_after_rst_b", en_b, 1);

    // 1: step every 4 clocks, capture timing per latency.
    run = 1'b1;
    q_a.push_back(4'd1); q_a.push_back(4'd2); q_a.push_back(4'd3);
    q_b.push_back(4'd1); q_b.push_back(4'd2); q_b.push_back(4'd3);
    for (int k = 0; k < 13; k++) begin
      cyc(1);
      chk_addr_wrap("t1", t1[k], 0);
      chk("t1_valid_a", valid_a, (k == 5 || k == 9) ? 1 : 0);
      chk("t1_valid_b", valid_b, (k == 7 || k == 11) ? 1 : 0);
    end
    run = 1'b0;
    cyc(6);
    chk_empty("t1");

    // 2: down-wrap from address 0 at one step per clock.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    dir = 1'b1; pmax = 23'd0; run = 1'b1;
    q_a.push_back(4'hF); q_a.push_back(4'hE); q_a.push_back(4'hD); q_a.push_back(4'hC);
    q_b.push_back(4'hF); q_b.push_back(4'hE); q_b.push_back(4'hD); q_b.push_back(4'hC);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk_addr_wrap("t2", t2a[k], t2w[k]);
    end
    run = 1'b0;
    cyc(6);
    chk_empty("t2");

    // 3: decouple mid-run; outstanding reads complete, then isolation.
    dir = 1'b0; run = 1'b1;
    q_a.push_back(4'hD); q_a.push_back(4'hE); q_a.push_back(4'hF); q_a.push_back(4'h0);
    q_b.push_back(4'hD); q_b.push_back(4'hE); q_b.push_back(4'hF); q_b.push_back(4'h0);
    cyc(5);
    chk_addr_wrap("t3_pre", 0, 0);
    dreq = 1'b1;
    cyc(1);
    chk_addr_wrap("t3_upwrap", 0, 1);
    base_a = cnt_a; base_b = cnt_b;
    wait_acks("t3");
    chk("t3_reads_a", cnt_a - base_a, 1);
    chk("t3_reads_b", cnt_b - base_b, 3);
    chk_addr_wrap("t3_held", 0, 0);
    cyc(2);
    chk("t3_hold_ack_b", ack_b, 1);
    dreq = 1'b0; run = 1'b0;
    cyc(1);
    chk("t3_ackfall_a", ack_a, 0); chk("t3_ackfall_b", ack_b, 0);
    chk("t3_enrise_a", en_a, 1);   chk("t3_enrise_b", en_b, 1);
    cyc(2);
    chk_addr_wrap("t3_idle", 0, 0);
    chk_empty("t3");

    // 4: decouple on the tick cycle suppresses the step and its read.
    pmax = 23'd5; run = 1'b1;
    base_a = cnt_a; base_b = cnt_b;
    cyc(6);
    chk_addr_wrap("t4_pre", 0, 0);
    dreq = 1'b1;
    cyc(1);
    chk_addr_wrap("t4_collide", 0, 0);
    wait_acks("t4");
    chk_addr_wrap("t4_held", 0, 0);
    chk("t4_reads_a", cnt_a - base_a, 0);
    chk("t4_reads_b", cnt_b - base_b, 0);
    dreq = 1'b0; run = 1'b0;
    cyc(2);

    // 5: presc_max lowered below a running count.
    pmax = 23'd20; run = 1'b1;
    cyc(11);
    chk_addr_wrap("t5_pre", 0, 0);
    pmax = 23'd4;
    q_a.push_back(4'd1); q_a.push_back(4'd2); q_a.push_back(4'd3);
    q_b.push_back(4'd1); q_b.push_back(4'd2); q_b.push_back(4'd3);
    for (int k = 0; k < 11; k++) begin
      cyc(1);
      chk_addr_wrap("t5", t5[k], 0);
    end
    run = 1'b0;
    cyc(6);
    chk_empty("t5");

    // 6: reset during DRAIN discards reads still in the latency-3 pipe.
    pmax = 23'd0; run = 1'b1;
    q_a.push_back(4'd4); q_a.push_back(4'd5); q_a.push_back(4'd6);
    q_b.push_back(4'd4);
    cyc(4);
    chk_addr_wrap("t6_pre", 6, 0);
    dreq = 1'b1;
    cyc(1);
    #5;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    dreq = 1'b0; run = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_en_a", en_a, 1); chk("t6_en_b", en_b, 1);
    base_a = cnt_a; base_b = cnt_b;
    cyc(8);
    chk("t6_no_reads_a", cnt_a - base_a, 0);
    chk("t6_no_reads_b", cnt_b - base_b, 0);
    chk_empty("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
